// File: rtl/alu_addsub_serial.sv
// Multi-cycle add/subtract unit: STEP-bit slices per clock, 8085-style flags.
// Optional signed-overflow flag enabled with `define ALU_ADDSUB_OVF_EN.
module alu_addsub_serial #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] oS,
    output logic             oC,
    output logic             oZ,
    output logic             oP,
    output logic             oA,
    output logic             oV
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, s_acc;
    logic             sub_q, carry_q, aux_q;
    logic             last;

    logic [WIDTH-1:0] s_w, s_new;
    logic             c, c_n, ab, bb, aux;
    int               bit_base;

`ifdef ALU_ADDSUB_OVF_EN
    logic msb_q, msb_in;
`endif

    assign last = (cnt == CW'(N - 1));

    // Operands shift right one slice per clock; the sum fills in from the top.
    always_comb begin
        c        = carry_q;
        c_n      = 1'b0;
        ab       = 1'b0;
        bb       = 1'b0;
        aux      = aux_q;
        s_w      = '0;
        bit_base = int'(cnt) * STEP;
`ifdef ALU_ADDSUB_OVF_EN
        msb_in   = msb_q;
`endif
        for (int i = 0; i < STEP; i++) begin
            ab = a_q[i];
            bb = b_q[i];
            s_w[WIDTH-STEP+i] = ab ^ bb ^ c;
            if (sub_q)
                c_n = (~ab & bb) | (~(ab ^ bb) & c);
            else
                c_n = (ab & bb) | ((ab ^ bb) & c);
            if (bit_base + i == 3)
                aux = c_n;
`ifdef ALU_ADDSUB_OVF_EN
            if (bit_base + i == WIDTH - 1)
                msb_in = c;
`endif
            c = c_n;
        end
        s_new = (s_acc >> STEP) | s_w;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_acc   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            aux_q   <= 1'b0;
`ifdef ALU_ADDSUB_OVF_EN
            msb_q   <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            cnt     <= '0;
            a_q     <= iA;
            b_q     <= iB;
            s_acc   <= '0;
            sub_q   <= sub;
            carry_q <= iC;
            aux_q   <= 1'b0;
`ifdef ALU_ADDSUB_OVF_EN
            msb_q   <= 1'b0;
`endif
        end else if (state == RUN) begin
            cnt     <= cnt + CW'(1);
            a_q     <= a_q >> STEP;
            b_q     <= b_q >> STEP;
            s_acc   <= s_new;
            carry_q <= c;
            aux_q   <= aux;
`ifdef ALU_ADDSUB_OVF_EN
            msb_q   <= msb_in;
`endif
        end
    end

    // Visible outputs change only on the final slice, never mid-run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oS <= '0;
            oC <= 1'b0;
            oZ <= 1'b0;
            oP <= 1'b0;
            oA <= 1'b0;
            oV <= 1'b0;
        end else if (state == RUN && last) begin
            oS <= s_new;
            oC <= c;
            oZ <= ~|s_new;
            oP <= ~^s_new;
            oA <= aux;
`ifdef ALU_ADDSUB_OVF_EN
            oV <= msb_in ^ c;
`else
            oV <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_alu_addsub_serial.sv
// Randomised bench for alu_addsub_serial: three configurations (8/1, 16/4, 8/8)
// compared against an arithmetic reference model.
module tb_alu_addsub_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st [3];
    logic        sub = 1'b0;
    logic        ic = 1'b0;
    logic [15:0] ia = '0;
    logic [15:0] ib = '0;

    logic        bz [3];
    logic        dn [3];
    logic        c_o [3];
    logic        z_o [3];
    logic        p_o [3];
    logic        a_o [3];
    logic        v_o [3];
    logic [15:0] s_o [3];
    logic [7:0]  s8, s88;

    int errors = 0;
    int checks = 0;

    int W  [3] = '{8, 16, 8};
    int NC [3] = '{8, 4, 1};

    always #5 clk = ~clk;

    alu_addsub_serial #(.WIDTH(8), .STEP(1)) u_w8s1 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub),
        .iA(ia[7:0]), .iB(ib[7:0]), .iC(ic),
        .busy(bz[0]), .done(dn[0]), .oS(s8), .oC(c_o[0]),
        .oZ(z_o[0]), .oP(p_o[0]), .oA(a_o[0]), .oV(v_o[0])
    );

    alu_addsub_serial #(.WIDTH(16), .STEP(4)) u_w16s4 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub),
        .iA(ia), .iB(ib), .iC(ic),
        .busy(bz[1]), .done(dn[1]), .oS(s_o[1]), .oC(c_o[1]),
        .oZ(z_o[1]), .oP(p_o[1]), .oA(a_o[1]), .oV(v_o[1])
    );

    alu_addsub_serial #(.WIDTH(8), .STEP(8)) u_w8s8 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub),
        .iA(ia[7:0]), .iB(ib[7:0]), .iC(ic),
        .busy(bz[2]), .done(dn[2]), .oS(s88), .oC(c_o[2]),
        .oZ(z_o[2]), .oP(p_o[2]), .oA(a_o[2]), .oV(v_o[2])
    );

    assign s_o[0] = {8'h00, s8};
    assign s_o[2] = {8'h00, s88};

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(
        input int w, input bit sb, input longint a_in, input longint b_in,
        input bit c, output longint s, output bit co, output bit z,
        output bit p, output bit ax, output bit v
    );
        longint mask, a, b, full, sa, sbv, r, lim;
        mask = (longint'(1) << w) - 1;
        a    = a_in & mask;
        b    = b_in & mask;
        if (!sb) begin
            full = a + b + longint'(c);
            s    = full & mask;
            co   = ((full >> w) & 1) != 0;
            ax   = ((a & 15) + (b & 15) + longint'(c)) > 15;
        end else begin
            s  = (a - b - longint'(c)) & mask;
            co = a < (b + longint'(c));
            ax = (a & 15) < ((b & 15) + longint'(c));
        end
        z   = (s == 0);
        p   = ($countones(s) % 2) == 0;
        lim = longint'(1) << (w - 1);
        sa  = (a >= lim) ? a - (mask + 1) : a;
        sbv = (b >= lim) ? b - (mask + 1) : b;
        r   = sb ? sa - sbv - longint'(c) : sa + sbv + longint'(c);
`ifdef ALU_ADDSUB_OVF_EN
        v = (r >= lim) || (r < -lim);
`else
        v = (r == r) && 1'b0;
`endif
    endfunction

    // Launch one operation on all three units; poke re-asserts start on the
    // 8/1 unit mid-run, which must be ignored.
    task automatic op(input bit sb, input logic [15:0] a, input logic [15:0] b,
                      input bit c, input int poke);
        int     lat [3];
        int     cnt [3];
        longint es;
        bit     eco, ez, ep, ea, ev;
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1;
            cnt[i] = 0;
        end
        @(negedge clk);
        sub = sb; ia = a; ib = b; ic = c;
        for (int i = 0; i < 3; i++) st[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) st[i] = 1'b0;
        ia = 16'($urandom); ib = 16'($urandom);
        ic = 1'($urandom); sub = 1'($urandom);
        for (int i = 0; i < 3; i++) chk("busy_after_start", bz[i], 1);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (dn[i]) begin
                    cnt[i]++;
                    if (lat[i] < 0) lat[i] = cyc;
                end
            end
            st[0] = (cyc == poke);
        end
        st[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model(W[i], sb, longint'(a), longint'(b), c, es, eco, ez, ep, ea, ev);
            chk("latency", lat[i], NC[i]);
            chk("done_pulses", cnt[i], 1);
            chk("busy_idle", bz[i], 0);
            chk("oS", s_o[i], es);
            chk("oC", c_o[i], eco);
            chk("oZ", z_o[i], ez);
            chk("oP", p_o[i], ep);
            chk("oA", a_o[i], ea);
            chk("oV", v_o[i], ev);
        end
    endtask

    initial begin
        int dcnt;
        for (int i = 0; i < 3; i++) st[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", bz[i], 0);
            chk("rst_done", dn[i], 0);
            chk("rst_oS", s_o[i], 0);
            chk("rst_flags", {c_o[i], z_o[i], p_o[i], a_o[i], v_o[i]}, 0);
        end
        rst_n = 1'b1;

        op(1'b1, 16'h0005, 16'h0003, 1'b0, 0);
        chk("t1_oS", s_o[0], 'h02);
        chk("t1_flags", {c_o[0], z_o[0], p_o[0], a_o[0]}, 0);
        op(1'b1, 16'h0000, 16'h0001, 1'b0, 0);
        chk("t2a_oS", s_o[0], 'hFF);
        op(1'b1, 16'h0000, 16'h0000, 1'b1, 0);
        chk("t2b_flags", {c_o[0], z_o[0], p_o[0], a_o[0]}, 'b1011);
        op(1'b0, 16'h00FF, 16'h0001, 1'b0, 3);
        chk("t3_flags", {c_o[0], z_o[0], p_o[0], a_o[0]}, 'b1111);
        op(1'b1, 16'h1000, 16'h0001, 1'b0, 0);
        chk("t5_oS", s_o[1], 'h0FFF);
        op(1'b0, 16'h007F, 16'h0001, 1'b0, 0);
        op(1'b1, 16'h0080, 16'h0001, 1'b0, 0);
        op(1'b1, 16'h0005, 16'h0003, 1'b0, 0);

        // Abort 0x12+0x34 with a one-edge reset four edges into the run.
        @(negedge clk);
        sub = 1'b0; ia = 16'h0012; ib = 16'h0034; ic = 1'b0;
        for (int i = 0; i < 3; i++) st[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) st[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", bz[0], 0);
        chk("abort_oS", s_o[0], 0);
        chk("abort_flags", {c_o[0], z_o[0], p_o[0], a_o[0], v_o[0]}, 0);
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn[0]) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        op(1'b0, 16'h0012, 16'h0034, 1'b0, 0);
        chk("t4_oS", s_o[0], 'h46);
        chk("t4_oC", c_o[0], 0);

        for (int n = 0; n < 40; n++)
            op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
               (n % 4 == 0) ? int'($urandom_range(1, 7)) : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
